serial_link_arbiter: RTL and testbench
======================================

Name: serial_link_arbiter

Overview:
- Round-robin scheduler and framer that shares one serial line between 4 parallel-word requesters.
- Each requester holds `req_i` with a stable N-bit word until it is acknowledged.
- The arbiter grants one requester, captures its word, and shifts out a framed packet: start bit, 2-bit source ID, data.
- Sits upstream of `serial_to_parallel`-style receivers. It replaces a free-running `parallel_to_serial` when several counters or sources need the link.

Parameters:
- N, 4, data word width in bits (N >= 1).
- GAP, 1, idle cycles forced low between frames (GAP >= 0).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- req, input, 4, request per source; bit k = source k.
- data_0, input, N, word from source 0; must be stable while req[0]=1.
- data_1, input, N, word from source 1.
- data_2, input, N, word from source 2.
- data_3, input, N, word from source 3.
- ack, output, 4, one-cycle acknowledge to the granted source.
- grant_id, output, 2, ID of the source being transmitted; valid while busy=1.
- busy, output, 1, high whenever state != IDLE.
- done_tick, output, 1, one-cycle pulse after the last frame bit is sent.
- serial_out, output, 1, serial line; idles at 0.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; serial_out=0; ack=0; busy=0; done_tick=0; grant_id=0.
  - Round-robin pointer last=3, so source 0 has top priority after reset.
  - A frame in progress is discarded with no done_tick.
- All other registers update on the rising edge of clk. All outputs are registered.
- States and transitions:
  - IDLE: serial_out=0.
    - If req != 0 at the edge: select the first set bit scanning last+1, last+2, … modulo 4.
    - Load the shift register with the selected data_k; grant_id=k; last=k; ack[k]=1 for the next cycle only; go to START.
  - START: 1 cycle, serial_out=1.
  - ID: 2 cycles, grant_id MSB first.
  - DATA: N cycles, captured word MSB first.
  - GAP: GAP cycles, serial_out=0. Skipped entirely when GAP=0.
  - Return to IDLE.
- done_tick:
  - Asserted for exactly the one cycle after the last DATA bit (first GAP cycle, or the IDLE cycle when GAP=0).
- Latency and throughput:
  - req seen in IDLE at edge t → ack and start bit both present in cycle t+1.
  - Frame length is 3+N bit-cycles.
  - Minimum repetition period is 1 (IDLE) + 3 + N + GAP cycles; IDLE is always visited for at least one cycle.
- Handshake:
  - Requester must hold req and data until it sees ack, then may drop or re-raise req.
  - A req still high after ack requests a new frame.
  - Source data is sampled only at the grant edge; later changes do not affect the frame in flight.
- Boundary conditions:
  - Simultaneous requests: only one grant per IDLE visit, chosen by round-robin.
  - A requester is never granted twice in a row while another requester is pending.
  - req deasserted before grant: no frame; arbiter stays in IDLE.
  - req arriving mid-frame: ignored until the next IDLE.
  - Pointer wraps 3→0.

Optional Feature:
- Macro: SERIAL_LINK_ARBITER_PARITY_EN.
- Defined:
  - A PARITY state (1 cycle) is inserted after DATA.
  - It sends even parity over the ID and data bits: XOR of the 2+N bits.
  - Frame length becomes 4+N.
  - done_tick moves to the cycle after the parity bit.
- Undefined: no parity state; frame as above.

Test Plan (N=4, GAP=1):
- Reset asserted mid-idle → serial_out=0, ack=0, busy=0, done_tick=0, grant_id=0 immediately, without waiting for a clk edge.
- Single request, req=4'b0100, data_2=4'b1011, raised at edge t:
  - ack=4'b0100 only in cycle t+1.
  - serial_out = 1,1,0,1,0,1,1 over cycles t+1..t+7, then 0.
  - done_tick=1 in cycle t+8; busy low from t+9.
- All four req held high → grant order 0,1,2,3,0; consecutive start bits 9 cycles apart.
- After a grant to source 1, raise req=4'b1001 → source 3 is granted first, then source 0.
- Reset asserted during DATA bit 2:
  - serial_out drops to 0 asynchronously; no done_tick.
  - After release, req=4'b1111 grants source 0 first.
- With SERIAL_LINK_ARBITER_PARITY_EN, source 1, data=4'b0111 → serial_out = 1,0,1,0,1,1,1,0 (parity 0); done_tick one cycle after the parity bit.

Source files
------------

// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter: round-robin scheduler and framer that shares one serial
// line between four parallel-word sources.
// Frame on serial_out: start bit (1), 2-bit source ID MSB first, N data bits
// MSB first, then GAP forced-low cycles before the arbiter returns to IDLE.
// Optional build macro SERIAL_LINK_ARBITER_PARITY_EN inserts one even-parity
// bit (XOR of the ID and data bits) after the data bits.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line low; grant the next pending source in round-robin order
// S_START  | start bit (1) on the line
// S_ID     | two source-ID bits, MSB first
// S_DATA   | N captured data bits, MSB first
// S_PARITY | even parity over ID and data bits (parity build only)
// S_GAP    | GAP forced-low cycles after the frame; done_tick on the first
module serial_link_arbiter #(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [N-1:0] data_0,
  input  logic [N-1:0] data_1,
  input  logic [N-1:0] data_2,
  input  logic [N-1:0] data_3,
  output logic [3:0]   ack,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic         done_tick,
  output logic         serial_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ID     = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  // The down-counter holds (phase length - 1); it must reach the larger of
  // the ID phase (2), the data phase (N) and the gap phase (GAP).
  localparam int CNT_TOP = (N > GAP) ? ((N > 2) ? N : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CW      = $clog2(CNT_TOP);
  localparam logic [CW-1:0] N_LOAD   = CW'(N - 1);
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [1:0]    last, last_nxt;
  logic [1:0]    grant_id_nxt;
  logic [3:0]    ack_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          serial_nxt;

  logic          found;
  logic [1:0]    sel;
  logic [1:0]    idx;
  logic [N-1:0]  data_sel;
  logic          frame_end;

`ifdef SERIAL_LINK_ARBITER_PARITY_EN
  logic          par, par_nxt;
`endif

  // Round-robin pick: first pending source scanning last+1 .. last+4 (mod 4).
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Word of the selected source, captured only at the grant edge.
  always_comb begin
    case (sel)
      2'd0:    data_sel = data_0;
      2'd1:    data_sel = data_1;
      2'd2:    data_sel = data_2;
      default: data_sel = data_3;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      last       <= 2'd3;
      grant_id   <= 2'd0;
      ack        <= 4'd0;
      busy       <= 1'b0;
      done_tick  <= 1'b0;
      serial_out <= 1'b0;
`ifdef SERIAL_LINK_ARBITER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      last       <= last_nxt;
      grant_id   <= grant_id_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      done_tick  <= done_nxt;
      serial_out <= serial_nxt;
`ifdef SERIAL_LINK_ARBITER_PARITY_EN
      par        <= par_nxt;
`endif
    end
  end

  // Next state plus next value of every registered output; serial_nxt is the
  // bit that will be on the line during the following cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    last_nxt     = last;
    grant_id_nxt = grant_id;
    ack_nxt      = 4'd0;
    done_nxt     = 1'b0;
    serial_nxt   = 1'b0;
    frame_end    = 1'b0;
`ifdef SERIAL_LINK_ARBITER_PARITY_EN
    par_nxt      = par;
`endif

    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt    = S_START;
          shreg_nxt    = data_sel;
          grant_id_nxt = sel;
          last_nxt     = sel;
          ack_nxt[sel] = 1'b1;
          serial_nxt   = 1'b1;
`ifdef SERIAL_LINK_ARBITER_PARITY_EN
          par_nxt      = (^data_sel) ^ sel[1] ^ sel[0];
`endif
        end
      end

      S_START: begin
        state_nxt  = S_ID;
        cnt_nxt    = CW'(1);
        serial_nxt = grant_id[1];
      end

      S_ID: begin
        if (cnt != '0) begin
          cnt_nxt    = cnt - CW'(1);
          serial_nxt = grant_id[0];
        end else begin
          state_nxt  = S_DATA;
          cnt_nxt    = N_LOAD;
          serial_nxt = shreg[N-1];
          shreg_nxt  = shreg << 1;
        end
      end

      S_DATA: begin
        if (cnt != '0) begin
          cnt_nxt    = cnt - CW'(1);
          serial_nxt = shreg[N-1];
          shreg_nxt  = shreg << 1;
        end else begin
`ifdef SERIAL_LINK_ARBITER_PARITY_EN
          state_nxt  = S_PARITY;
          serial_nxt = par;
`else
          frame_end  = 1'b1;
`endif
        end
      end

`ifdef SERIAL_LINK_ARBITER_PARITY_EN
      S_PARITY: begin
        frame_end = 1'b1;
      end
`endif

      S_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Last frame bit just finished: pulse done_tick and either pad with the
    // gap or fall straight back to IDLE.
    if (frame_end) begin
      done_nxt = 1'b1;
      if (GAP > 0) begin
        state_nxt = S_GAP;
        cnt_nxt   = GAP_LOAD;
      end else begin
        state_nxt = S_IDLE;
      end
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed testbench for serial_link_arbiter (N=4, GAP=1).
module tb_serial_link_arbiter;

  localparam int N   = 4;
  localparam int GAP = 1;
`ifdef SERIAL_LINK_ARBITER_PARITY_EN
  localparam int FL  = 8;
`else
  localparam int FL  = 7;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [N-1:0] data_0, data_1, data_2, data_3;
  logic [3:0]   ack;
  logic [1:0]   grant_id;
  logic         busy, done_tick, serial_out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  serial_link_arbiter #(.N(N), .GAP(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data_0     (data_0),
    .data_1     (data_1),
    .data_2     (data_2),
    .data_3     (data_3),
    .ack        (ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .done_tick  (done_tick),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Advance until an ack is seen (sampled 1 after the edge), bounded.
  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ack != 4'd0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b want 0", serial_out); end
    checks++; if (ack !== 4'd0) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_tick); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (serial_out !== 1'b0 || ack !== 4'd0 || busy !== 1'b0 || done_tick !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_mid_idle: got ser=%b ack=%b busy=%b done=%b gid=%0d want all 0",
                         serial_out, ack, busy, done_tick, grant_id);
    end
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic test_single;
    logic [8:0] ser_pat;
    logic       exp_ser;
    logic [3:0] exp_ack;
    ser_pat = 9'b110101100;
    @(posedge clk); #1;
    data_2 = 4'b1011;
    req    = 4'b0100;
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      exp_ser = ser_pat[9-c];
      exp_ack = (c == 1) ? 4'b0100 : 4'd0;
      checks++; if (serial_out !== exp_ser) begin errors++; $display("FAIL single_serial c=%0d: got %b want %b", c, serial_out, exp_ser); end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL single_ack c=%0d: got %b want %b", c, ack, exp_ack); end
      checks++; if (done_tick !== (c == 8)) begin errors++; $display("FAIL single_done c=%0d: got %b want %b", c, done_tick, (c == 8)); end
      checks++; if (busy !== (c <= 8)) begin errors++; $display("FAIL single_busy c=%0d: got %b want %b", c, busy, (c <= 8)); end
      if (c == 1) begin
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
        req    = 4'd0;
        data_2 = 4'b0000;
      end
      if (c < 9) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_round_robin;
    bit         ok;
    int         prev;
    logic [1:0] exp_id;
    #1 reset = 1'b1;
    #4 reset = 1'b0;
    @(posedge clk); #1;
    data_0 = 4'h1; data_1 = 4'h2; data_2 = 4'h4; data_3 = 4'h8;
    req = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      exp_id = 2'(n % 4);
      wait_ack(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rr_timeout n=%0d: got no ack want ack", n);
      end else if (grant_id !== exp_id || ack !== (4'd1 << exp_id) || serial_out !== 1'b1) begin
        errors++; $display("FAIL rr_grant n=%0d: got gid=%0d ack=%b ser=%b want gid=%0d start bit 1",
                           n, grant_id, ack, serial_out, exp_id);
      end
      if (n > 0) begin
        checks++; if (cycle - prev != 9) begin errors++; $display("FAIL rr_period n=%0d: got %0d want 9", n, cycle - prev); end
      end
      prev = cycle;
    end
    req = 4'd0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_rr_pointer;
    bit ok;
    int prev;
    req = 4'b0010;
    wait_ack(ok);
    checks++; if (!ok || grant_id !== 2'd1) begin errors++; $display("FAIL ptr_first: got ok=%b gid=%0d want gid=1", ok, grant_id); end
    prev = cycle;
    req = 4'b1001;
    wait_ack(ok);
    checks++; if (!ok || grant_id !== 2'd3 || ack !== 4'b1000) begin errors++; $display("FAIL ptr_second: got gid=%0d ack=%b want gid=3 ack=1000", grant_id, ack); end
    checks++; if (cycle - prev != 9) begin errors++; $display("FAIL ptr_midframe_wait: got %0d want 9", cycle - prev); end
    prev = cycle;
    req = 4'b0001;
    wait_ack(ok);
    checks++; if (!ok || grant_id !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL ptr_wrap: got gid=%0d ack=%b want gid=0 ack=0001", grant_id, ack); end
    checks++; if (cycle - prev != 9) begin errors++; $display("FAIL ptr_wrap_period: got %0d want 9", cycle - prev); end
    req = 4'd0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_req_drop;
    bit ok;
    int ack_seen;
    req = 4'b0100;
    wait_ack(ok);
    checks++; if (!ok || grant_id !== 2'd2) begin errors++; $display("FAIL drop_grant: got gid=%0d want 2", grant_id); end
    req = 4'd0;
    repeat (3) @(posedge clk);
    #1 req = 4'b1000;
    repeat (2) @(posedge clk);
    #1 req = 4'd0;
    ack_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ack != 4'd0) ack_seen++;
    end
    checks++; if (ack_seen != 0) begin errors++; $display("FAIL drop_no_grant: got %0d acks want 0", ack_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int done_seen;
    data_1 = 4'b1111;
    req    = 4'b0010;
    wait_ack(ok);
    checks++; if (!ok || grant_id !== 2'd1) begin errors++; $display("FAIL rst_setup: got gid=%0d want 1", grant_id); end
    req = 4'd0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (serial_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_databit: got ser=%b busy=%b want 1 1", serial_out, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (serial_out !== 1'b0 || busy !== 1'b0 || ack !== 4'd0 || done_tick !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rst_async: got ser=%b busy=%b ack=%b done=%b gid=%0d want all 0",
                         serial_out, busy, ack, done_tick, grant_id);
    end
    @(posedge clk); #2 reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_tick !== 1'b0) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses want 0", done_seen); end
    req = 4'b1111;
    wait_ack(ok);
    checks++; if (!ok || grant_id !== 2'd0) begin errors++; $display("FAIL rst_priority: got gid=%0d want 0", grant_id); end
    req = 4'd0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_frame_src1;
    logic [9:0] pat;
    logic       exp_ser;
    pat = 10'b1010111000;
    data_1 = 4'b0111;
    req    = 4'b0010;
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0010 || grant_id !== 2'd1) begin errors++; $display("FAIL src1_ack: got ack=%b gid=%0d want 0010 1", ack, grant_id); end
    req = 4'd0;
    for (int c = 1; c <= FL + 2; c++) begin
      exp_ser = pat[10-c];
      checks++; if (serial_out !== exp_ser) begin errors++; $display("FAIL src1_serial c=%0d: got %b want %b", c, serial_out, exp_ser); end
      checks++; if (done_tick !== (c == FL + 1)) begin errors++; $display("FAIL src1_done c=%0d: got %b want %b", c, done_tick, (c == FL + 1)); end
      checks++; if (busy !== (c <= FL + 1)) begin errors++; $display("FAIL src1_busy c=%0d: got %b want %b", c, busy, (c <= FL + 1)); end
      if (c < FL + 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    req    = 4'd0;
    data_0 = '0;
    data_1 = '0;
    data_2 = '0;
    data_3 = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_rr_pointer;
    test_req_drop;
    test_reset_mid_frame;
    test_frame_src1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
